counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 97 +++++++++
 tb/tb_counter_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// counter_checker: tracks an external free-running counter against the model
// value(k+1) = value(k) + enable(k), flags mismatches, counts errors
// (saturating) and observed all-ones-to-zero rollovers (wrapping).
module counter_checker #(
  parameter int CNT_W       = 4,
  parameter int ERR_W       = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] counter_value_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_o,
  output logic             error_sticky_o,
  output logic [ERR_W-1:0] error_count_o,
  output logic [ERR_W-1:0] wrap_count_o
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [2:0] THRESH = 3'(LOSS_THRESH);

  state_t           state;
  logic [CNT_W-1:0] prev_value;
  logic             prev_enable;
  logic [2:0]       miss_cnt;

  logic [CNT_W-1:0] expected;
  logic             mismatch;
  logic             wrap_hit;

  // Expected value from the previous sample; a glitch re-seeds from what was seen.
  always_comb begin
    expected = prev_value + CNT_W'(prev_enable);
    mismatch = (counter_value_i != expected);
    wrap_hit = (prev_value == '1) && prev_enable && (counter_value_i == '0);
  end

  assign locked_o = (state == LOCKED);

  // Lock FSM, error pulse/sticky/counters and sample history.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= UNLOCKED;
      prev_value     <= '0;
      prev_enable    <= 1'b0;
      miss_cnt       <= '0;
      error_o        <= 1'b0;
      error_sticky_o <= 1'b0;
      error_count_o  <= '0;
      wrap_count_o   <= '0;
    end else begin
      prev_value  <= counter_value_i;
      prev_enable <= enable_i;
      error_o     <= 1'b0;
      if (clear_i) begin
        state          <= UNLOCKED;
        miss_cnt       <= '0;
        error_sticky_o <= 1'b0;
        error_count_o  <= '0;
        wrap_count_o   <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            state    <= LOCKED;
            miss_cnt <= '0;
          end
          LOCKED: begin
            if (mismatch) begin
              error_o        <= 1'b1;
              error_sticky_o <= 1'b1;
              if (error_count_o != '1)
                error_count_o <= error_count_o + 1'b1;
              if ((miss_cnt + 3'd1) >= THRESH) begin
                state    <= UNLOCKED;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end else begin
              miss_cnt <= '0;
              if (wrap_hit)
                wrap_count_o <= wrap_count_o + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker with hand-computed expectations.
module tb_counter_checker;

  logic       clock_i = 1'b0;
  logic       reset_n_i;
  logic       enable_i;
  logic [3:0] counter_value_i;
  logic       clear_i;
  logic       locked_o;
  logic       error_o;
  logic       error_sticky_o;
  logic [7:0] error_count_o;
  logic [7:0] wrap_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  counter_checker #(
    .CNT_W(4),
    .ERR_W(8),
    .LOSS_THRESH(3)
  ) dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .counter_value_i(counter_value_i),
    .clear_i        (clear_i),
    .locked_o       (locked_o),
    .error_o        (error_o),
    .error_sticky_o (error_sticky_o),
    .error_count_o  (error_count_o),
    .wrap_count_o   (wrap_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, clock it in, sample outputs 1ns after the edge.
  task automatic step(input int val, input logic en, input logic clr);
    counter_value_i = 4'(val);
    enable_i        = en;
    clear_i         = clr;
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, int'(locked_o), 0);
    check({tag, "_err"},    int'(error_o), 0);
    check({tag, "_sticky"}, int'(error_sticky_o), 0);
    check({tag, "_ecnt"},   int'(error_count_o), 0);
    check({tag, "_wcnt"},   int'(wrap_count_o), 0);
  endtask

  initial begin
    reset_n_i       = 1'b0;
    enable_i        = 1'b0;
    counter_value_i = '0;
    clear_i         = 1'b0;

    // Reset state
    repeat (2) @(posedge clock_i);
    #1;
    check_all_zero("reset");
    @(negedge clock_i);
    reset_n_i = 1'b1;

    // Correct count 0..15, 0..3 with enable high
    for (int i = 0; i < 20; i++) begin
      step(i % 16, 1'b1, 1'b0);
      check("run_err", int'(error_o), 0);
      if (i >= 1) check("run_locked", int'(locked_o), 1);
    end
    check("run_wrap", int'(wrap_count_o), 1);
    check("run_ecnt", int'(error_count_o), 0);
    check("run_sticky", int'(error_sticky_o), 0);

    // Single glitch 5 -> 9, then 9 -> 6 also mismatches
    step(4, 1'b1, 1'b0);
    check("g_pre_err", int'(error_o), 0);
    step(9, 1'b1, 1'b0);
    check("g1_err", int'(error_o), 1);
    check("g1_ecnt", int'(error_count_o), 1);
    check("g1_sticky", int'(error_sticky_o), 1);
    check("g1_locked", int'(locked_o), 1);
    step(6, 1'b1, 1'b0);
    check("g2_err", int'(error_o), 1);
    check("g2_ecnt", int'(error_count_o), 2);
    check("g2_locked", int'(locked_o), 1);
    step(7, 1'b1, 1'b0);
    check("g3_err", int'(error_o), 0);
    check("g3_ecnt", int'(error_count_o), 2);
    check("g3_locked", int'(locked_o), 1);

    // Second glitch to bring count to 4
    step(8, 1'b1, 1'b0);
    step(12, 1'b1, 1'b0);
    step(10, 1'b1, 1'b0);
    step(11, 1'b1, 1'b0);
    check("g4_ecnt", int'(error_count_o), 4);
    check("g4_locked", int'(locked_o), 1);
    check("g4_err", int'(error_o), 0);

    // Asynchronous reset pulse between edges
    @(negedge clock_i);
    reset_n_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clock_i);
    reset_n_i = 1'b1;
    step(3, 1'b1, 1'b0);
    check("resync_locked", int'(locked_o), 1);
    check("resync_err", int'(error_o), 0);
    step(4, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    check("resync_err2", int'(error_o), 0);
    check("resync_ecnt", int'(error_count_o), 0);

    // Counter stuck at 7 with enable high -> lock loss after 3 misses
    step(6, 1'b1, 1'b0);
    step(7, 1'b1, 1'b0);
    check("stuck0_err", int'(error_o), 0);
    step(7, 1'b1, 1'b0);
    check("stuck1_err", int'(error_o), 1);
    check("stuck1_locked", int'(locked_o), 1);
    step(7, 1'b1, 1'b0);
    check("stuck2_err", int'(error_o), 1);
    check("stuck2_locked", int'(locked_o), 1);
    step(7, 1'b1, 1'b0);
    check("stuck3_err", int'(error_o), 1);
    check("stuck3_locked", int'(locked_o), 0);
    check("stuck3_ecnt", int'(error_count_o), 3);
    step(7, 1'b1, 1'b0);
    check("relock_locked", int'(locked_o), 1);
    check("relock_err", int'(error_o), 0);
    check("relock_ecnt", int'(error_count_o), 3);

    // Clear on the same edge as a mismatch
    step(2, 1'b1, 1'b1);
    check_all_zero("clear");
    step(3, 1'b1, 1'b0);
    check("clr_relock", int'(locked_o), 1);
    check("clr_relock_err", int'(error_o), 0);

    // Enable low: held value matches, changed value mismatches
    step(4, 1'b0, 1'b0);
    check("en0_a_err", int'(error_o), 0);
    step(4, 1'b0, 1'b0);
    check("en0_hold_err", int'(error_o), 0);
    step(5, 1'b1, 1'b0);
    check("en0_move_err", int'(error_o), 1);
    check("en0_move_ecnt", int'(error_count_o), 1);
    step(6, 1'b1, 1'b0);
    check("en0_after_err", int'(error_o), 0);

    // Saturation: held value with enable high, 3 errors per 4 edges
    step(7, 1'b1, 1'b1);
    check("sat_clr_ecnt", int'(error_count_o), 0);
    for (int i = 0; i < 350; i++) step(7, 1'b1, 1'b0);
    check("sat_mid_ecnt", int'(error_count_o), 255);
    for (int i = 0; i < 50; i++) step(7, 1'b1, 1'b0);
    check("sat_end_ecnt", int'(error_count_o), 255);
    check("sat_sticky", int'(error_sticky_o), 1);
    check("sat_wcnt", int'(wrap_count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
